calendar_ctrl: RTL and testbench
================================

CALENDAR_CTRL -- requirements
Module: calendar_ctrl

Interface
REQ-001 Parameter YEAR_MAX, default 99, highest year value (offset from 2000) before year wraps to 0.
REQ-002 Parameter YEAR_RST, default 0, year value loaded at reset.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle pulse; advance calendar by one day.
REQ-006 mode  input  1  one-cycle pulse; step FSM RUN->SET_YEAR->SET_MONTH->SET_DAY->RUN.
REQ-007 inc  input  1  one-cycle pulse; increment field selected by current SET state.
REQ-008 year1, year2  output  4 each  BCD tens/units of year.
REQ-009 month1, month2  output  4 each  BCD tens/units of month (1..12).
REQ-010 day1, day2  output  4 each  BCD tens/units of day (1..limit).
REQ-011 limit  output  5  days in current month (28/29/30/31), combinational from month/year.
REQ-012 sel  output  2  edited field: 0 none (RUN), 1 year, 2 month, 3 day.
REQ-013 month_carry  output  1  registered one-cycle pulse when day wraps to 1.
REQ-014 year_carry  output  1  registered one-cycle pulse when month wraps 12->1.

Function
REQ-015 Internal day, month, year held as binary registers (5, 4, 7 bits); BCD outputs derived combinationally.
REQ-016 limit: months 4,6,9,11 -> 30; month 2 -> 29 if year mod 4 == 0, else 28; all others -> 31.
REQ-017 RUN, tick=1, day<limit: day+1 next cycle; month_carry, year_carry 0.
REQ-018 RUN, tick=1, day==limit: day<=1, month+1, month_carry=1 on following cycle.
REQ-019 RUN, tick=1, day==limit, month==12: day<=1, month<=1, year+1 (YEAR_MAX wraps to 0); month_carry=1 and year_carry=1 on same cycle.
REQ-020 SET states: tick ignored (dropped, not queued); carries stay 0.
REQ-021 SET_YEAR inc: year+1, YEAR_MAX->0. SET_MONTH inc: month+1, 12->1. SET_DAY inc: day+1, limit->1. No carry propagates during set.
REQ-022 After any year or month change, day SHALL be clamped to new limit on next edge (e.g. 31 Jan -> Feb of non-leap year -> 28).
REQ-023 mode and inc in same cycle: mode wins, inc ignored.
REQ-024 mode and tick in same cycle in RUN: state moves to SET_YEAR, tick dropped.
REQ-025 Latency: every pulse input takes effect on register outputs one clock after the sampling edge.
REQ-026 Day register never holds 0 or a value above limit after any edge.

Reset
REQ-027 rst low: day=1, month=1, year=YEAR_RST, state RUN, sel=0, month_carry=0, year_carry=0, immediately, independent of clk.
REQ-028 Reset asserted mid-set discards partially edited values; no tick or pulse during reset has effect.
REQ-029 First tick after rst deasserts is processed normally.

Structure
REQ-030 Shared package calendar_pkg holds FSM state encoding (RUN, SET_YEAR, SET_MONTH, SET_DAY), field codes for sel, and the month-length constants 28/29/30/31.
REQ-031 One sub-module month_len (combinational: month, year -> limit) SHALL be instantiated; binary-to-BCD split stays inline.

Verification
REQ-032 Reset, 31 ticks -> day 01..31 then 01, month 02, one month_carry pulse on wrap cycle.
REQ-033 Year 03, month 02, day 28, tick -> day 01 month 03; repeat with year 04 -> day 29, then 01.
REQ-034 Year 99, month 12, day 31, tick -> 01/01/00, month_carry and year_carry both high one cycle.
REQ-035 Set 31 Jan via mode/inc, then SET_MONTH inc (year 01) -> month 02, day clamped 28; tick during SET ignored.
REQ-036 mode+inc same cycle in SET_MONTH -> state SET_DAY, month unchanged; mode+tick in RUN -> SET_YEAR, day unchanged.
REQ-037 rst asserted mid-SET_DAY, between clock edges -> outputs 01/01/YEAR_RST, sel 0, carries 0, with no clock edge required.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared encodings for the calendar controller: FSM states, edited-field codes
// and month-length constants.
package calendar_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StSetYear  = 2'd1,
        StSetMonth = 2'd2,
        StSetDay   = 2'd3
    } cal_state_e;

    localparam logic [1:0] SelNone  = 2'd0;
    localparam logic [1:0] SelYear  = 2'd1;
    localparam logic [1:0] SelMonth = 2'd2;
    localparam logic [1:0] SelDay   = 2'd3;

    localparam logic [4:0] DaysFeb     = 5'd28;
    localparam logic [4:0] DaysFebLeap = 5'd29;
    localparam logic [4:0] DaysShort   = 5'd30;
    localparam logic [4:0] DaysLong    = 5'd31;

    localparam logic [3:0] MonthFeb = 4'd2;
    localparam logic [3:0] MonthDec = 4'd12;

endpackage

// File: rtl/month_len.sv
// Days in a month for a year offset from 2000; every year divisible by 4 is leap.
module month_len
    import calendar_pkg::*;
(
    input  logic [3:0] month,
    input  logic [6:0] year,
    output logic [4:0] limit
);

    always_comb begin
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: limit = DaysShort;
            MonthFeb:                limit = ((year % 7'd4) == 7'd0) ? DaysFebLeap : DaysFeb;
            default:                 limit = DaysLong;
        endcase
    end

endmodule

// File: rtl/calendar_ctrl.sv
// Day/month/year calendar with tick advance and a mode/inc field editor.
// State is binary; BCD digits are split combinationally at the outputs.
module calendar_ctrl
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_MAX = 99,
    parameter int unsigned YEAR_RST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode,
    input  logic       inc,
    output logic [3:0] year1,
    output logic [3:0] year2,
    output logic [3:0] month1,
    output logic [3:0] month2,
    output logic [3:0] day1,
    output logic [3:0] day2,
    output logic [4:0] limit,
    output logic [1:0] sel,
    output logic       month_carry,
    output logic       year_carry
);

    localparam logic [6:0] YearMax  = 7'(YEAR_MAX);
    localparam logic [6:0] YearInit = 7'(YEAR_RST);

    cal_state_e state_q, state_d;
    logic [4:0] day_q, day_n, day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q, year_d;
    logic [1:0] sel_q, sel_d;
    logic       month_carry_q, month_carry_d;
    logic       year_carry_q, year_carry_d;
    logic [4:0] limit_nxt;
    logic [6:0] year_inc;
    logic [3:0] month_inc;

    month_len u_len_cur (
        .month (month_q),
        .year  (year_q),
        .limit (limit)
    );

    // Length of the month being entered, used to clamp the day on the same edge.
    month_len u_len_nxt (
        .month (month_d),
        .year  (year_d),
        .limit (limit_nxt)
    );

    assign year_inc  = (year_q >= YearMax) ? 7'd0 : year_q + 7'd1;
    assign month_inc = (month_q >= MonthDec) ? 4'd1 : month_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        day_n         = day_q;
        month_d       = month_q;
        year_d        = year_q;
        month_carry_d = 1'b0;
        year_carry_d  = 1'b0;
        if (mode) begin
            // mode takes priority; a coincident tick or inc is dropped
            unique case (state_q)
                StRun:      state_d = StSetYear;
                StSetYear:  state_d = StSetMonth;
                StSetMonth: state_d = StSetDay;
                StSetDay:   state_d = StRun;
            endcase
        end else begin
            unique case (state_q)
                StRun: begin
                    if (tick) begin
                        if (day_q >= limit) begin
                            day_n         = 5'd1;
                            month_d       = month_inc;
                            month_carry_d = 1'b1;
                            if (month_q >= MonthDec) begin
                                year_d       = year_inc;
                                year_carry_d = 1'b1;
                            end
                        end else begin
                            day_n = day_q + 5'd1;
                        end
                    end
                end
                StSetYear: begin
                    if (inc) year_d = year_inc;
                end
                StSetMonth: begin
                    if (inc) month_d = month_inc;
                end
                StSetDay: begin
                    if (inc) day_n = (day_q >= limit) ? 5'd1 : day_q + 5'd1;
                end
            endcase
        end
    end

    assign day_d = (day_n > limit_nxt) ? limit_nxt : day_n;

    always_comb begin
        unique case (state_d)
            StRun:      sel_d = SelNone;
            StSetYear:  sel_d = SelYear;
            StSetMonth: sel_d = SelMonth;
            StSetDay:   sel_d = SelDay;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            day_q         <= 5'd1;
            month_q       <= 4'd1;
            year_q        <= YearInit;
            sel_q         <= SelNone;
            month_carry_q <= 1'b0;
            year_carry_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            day_q         <= day_d;
            month_q       <= month_d;
            year_q        <= year_d;
            sel_q         <= sel_d;
            month_carry_q <= month_carry_d;
            year_carry_q  <= year_carry_d;
        end
    end

    assign sel         = sel_q;
    assign month_carry = month_carry_q;
    assign year_carry  = year_carry_q;

    assign year1  = 4'(year_q / 7'd10);
    assign year2  = 4'(year_q % 7'd10);
    assign month1 = month_q / 4'd10;
    assign month2 = month_q % 4'd10;
    assign day1   = 4'(day_q / 5'd10);
    assign day2   = 4'(day_q % 5'd10);

endmodule

// File: tb/tb_calendar_ctrl.sv
// Scoreboard bench for calendar_ctrl: a behavioural calendar model predicts each
// cycle's outputs, which are queued and compared one edge later.
module tb_calendar_ctrl;

    localparam int unsigned YMAX = 99;
    localparam int unsigned YRST = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       mode = 1'b0;
    logic       inc = 1'b0;
    logic [3:0] year1, year2, month1, month2, day1, day2;
    logic [4:0] limit;
    logic [1:0] sel;
    logic       month_carry, year_carry;

    calendar_ctrl #(
        .YEAR_MAX (YMAX),
        .YEAR_RST (YRST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .mode        (mode),
        .inc         (inc),
        .year1       (year1),
        .year2       (year2),
        .month1      (month1),
        .month2      (month2),
        .day1        (day1),
        .day2        (day2),
        .limit       (limit),
        .sel         (sel),
        .month_carry (month_carry),
        .year_carry  (year_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] date;
        logic [4:0]  lim;
        logic [1:0]  sel;
        logic        mc;
        logic        yc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // behavioural model; mst: 0 run, 1 year, 2 month, 3 day (same numbering as sel)
    int md, mm, my, mst, mmc, myc;

    function automatic int mlen(input int m, input int y);
        case (m)
            4, 6, 9, 11: return 30;
            2:           return (y % 4 == 0) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md = 1; mm = 1; my = YRST; mst = 0; mmc = 0; myc = 0;
    endtask

    task automatic model_step(input logic t, input logic m, input logic i);
        mmc = 0;
        myc = 0;
        if (m) begin
            mst = (mst + 1) % 4;
        end else if (mst == 0 && t) begin
            if (md == mlen(mm, my)) begin
                md  = 1;
                mmc = 1;
                if (mm == 12) begin
                    mm  = 1;
                    myc = 1;
                    my  = (my == YMAX) ? 0 : my + 1;
                end else begin
                    mm++;
                end
            end else begin
                md++;
            end
        end else if (i) begin
            case (mst)
                1: my = (my == YMAX) ? 0 : my + 1;
                2: mm = (mm % 12) + 1;
                3: md = (md == mlen(mm, my)) ? 1 : md + 1;
                default: ;
            endcase
        end
        if (md > mlen(mm, my)) md = mlen(mm, my);
    endtask

    task automatic push_expected();
        exp_t e;
        e.date = {bcd8(my), bcd8(mm), bcd8(md)};
        e.lim  = 5'(mlen(mm, my));
        e.sel  = 2'(mst);
        e.mc   = mmc[0];
        e.yc   = myc[0];
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("date", {year1, year2, month1, month2, day1, day2}, e.date);
            check("limit", limit, e.lim);
            check("sel", sel, e.sel);
            check("month_carry", month_carry, e.mc);
            check("year_carry", year_carry, e.yc);
        end
    endtask

    task automatic cycle(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick = t;
        mode = m;
        inc  = i;
        model_step(t, m, i);
        push_expected();
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Reset asserted between edges, checked before any edge, then held across
    // two edges with pulses applied that must have no effect.
    task automatic async_reset();
        #2;
        rst  = 1'b0;
        tick = 1'b1;
        inc  = 1'b1;
        mode = 1'b0;
        model_reset();
        push_expected();
        #1;
        compare_out();
        repeat (2) begin
            @(posedge clk);
            #1;
            push_expected();
            compare_out();
        end
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        inc  = 1'b0;
    endtask

    task automatic set_date(input int y, input int m, input int d);
        cycle(0, 1, 0);
        for (int k = 0; k < 128 && my != y; k++) cycle(0, 0, 1);
        cycle(0, 1, 0);
        for (int k = 0; k < 16 && mm != m; k++) cycle(0, 0, 1);
        cycle(0, 1, 0);
        for (int k = 0; k < 32 && md != d; k++) cycle(0, 0, 1);
        cycle(0, 1, 0);
    endtask

    initial begin
        model_reset();
        async_reset();

        // 31 ticks through January into February
        for (int k = 0; k < 31; k++) cycle(1, 0, 0);
        cycle(0, 0, 0);

        // non-leap and leap end of February
        set_date(3, 2, 28);
        cycle(1, 0, 0);
        set_date(4, 2, 28);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        // year edit out of a leap year clamps 29 Feb to 28
        set_date(24, 2, 29);
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        // year wrap with both carries
        set_date(99, 12, 31);
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        // 31 Jan, month edit clamps day; ticks in SET states are dropped
        set_date(1, 1, 31);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);

        // mode wins over inc and over tick
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 1);

        // reset mid SET_DAY, then first tick is processed
        async_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
